// File: rtl/seg7_pkg.sv
// seg7_pkg
// Shared definitions for the multiplexed seven-segment scanner:
//   - SEG_BLANK     : active-high "all segments off" pattern
//   - digit_t       : one digit record (nibble, enable, blink, decimal point)
//   - blink_phase_t : lit / dark half of the blink cycle
//   - hexToSeg()    : 16-entry hex nibble to active-high segment table
// Segment bit order everywhere is bit0 = a ... bit6 = g.
package seg7_pkg;

  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  typedef struct packed {
    logic [3:0] nibble;
    logic       en;
    logic       blink;
    logic       dp;
  } digit_t;

  typedef enum logic {
    BLINK_ON  = 1'b0,
    BLINK_OFF = 1'b1
  } blink_phase_t;

  // Standard hex glyphs: 0-9, A, b, C, d, E, F (active-high, g..a).
  function automatic logic [6:0] hexToSeg(input logic [3:0] nibble);
    logic [6:0] seg;
    case (nibble)
      4'h0:    seg = 7'b0111111;
      4'h1:    seg = 7'b0000110;
      4'h2:    seg = 7'b1011011;
      4'h3:    seg = 7'b1001111;
      4'h4:    seg = 7'b1100110;
      4'h5:    seg = 7'b1101101;
      4'h6:    seg = 7'b1111101;
      4'h7:    seg = 7'b0000111;
      4'h8:    seg = 7'b1111111;
      4'h9:    seg = 7'b1101111;
      4'hA:    seg = 7'b1110111;
      4'hB:    seg = 7'b1111100;
      4'hC:    seg = 7'b0111001;
      4'hD:    seg = 7'b1011110;
      4'hE:    seg = 7'b1111001;
      default: seg = 7'b1110001;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// seg7_hex_decode
// Purely combinational hex nibble to seven-segment decoder. Output is
// always active-high; display polarity is applied by the scanner.
// Ports:
//   nibble_i : hex digit to show
//   seg_o    : active-high segments, bit0 = a ... bit6 = g
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  assign seg_o = hexToSeg(nibble_i);

endmodule

// File: rtl/seg7_scan_display.sv
// seg7_scan_display
// Time-multiplexed driver for a NUM_DIGITS seven-segment display. Each digit
// is given CLK_DIV clocks of dwell; the first GHOST_CYCLES of every dwell keep
// all outputs dark to stop ghosting while the digit lines switch. New content
// is written into staging registers with 'update' and only promoted to the
// displayed (active) registers at a frame boundary, so a frame never tears.
// Ports:
//   clk, rst    : clock and asynchronous active-high reset
//   value       : one hex nibble per digit, digit 0 in the LSBs
//   digit_en    : per-digit enable (0 = blank)
//   blink_mask  : per-digit blink enable
//   dp          : per-digit decimal point
//   update      : one-cycle strobe capturing value/digit_en/blink_mask/dp
//   pending     : staged content not yet shown
//   seg_out     : segments a..g in SEG_ACTIVE_LOW polarity
//   dp_out      : decimal point in SEG_ACTIVE_LOW polarity
//   dig_sel     : one-hot digit select in DIG_ACTIVE_LOW polarity
//   frame_pulse : one-cycle pulse as the scan returns to digit 0
// Optional feature: define SEG7_LEADING_ZERO_BLANK_EN to suppress leading
// zeros on the upper digits.
module seg7_scan_display
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int CLK_DIV        = 50000,
  parameter int GHOST_CYCLES   = 2,
  parameter int BLINK_FRAMES   = 125,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int DIG_ACTIVE_LOW = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  input  logic [NUM_DIGITS-1:0]   dp,
  input  logic                    update,
  output logic                    pending,
  output logic [6:0]              seg_out,
  output logic                    dp_out,
  output logic [NUM_DIGITS-1:0]   dig_sel,
  output logic                    frame_pulse
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [DW-1:0] DWELL_LAST = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] GHOST_END  = DW'(GHOST_CYCLES);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);
  localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);

  localparam logic SEG_INV = (SEG_ACTIVE_LOW != 0);
  localparam logic DIG_INV = (DIG_ACTIVE_LOW != 0);

  localparam logic [6:0]            SEG_OFF = SEG_BLANK ^ {7{SEG_INV}};
  localparam logic                  DP_OFF  = SEG_INV;
  localparam logic [NUM_DIGITS-1:0] DIG_OFF = {NUM_DIGITS{DIG_INV}};

  logic [DW-1:0] dwellCnt_q, dwellCnt_d;
  logic [IW-1:0] digIdx_q, digIdx_d;
  logic [FW-1:0] frameCnt_q, frameCnt_d;
  blink_phase_t  blinkPhase_q, blinkPhase_d;
  logic          dwellWrap, frameWrap;

  digit_t [NUM_DIGITS-1:0] staged_q, staged_d;
  digit_t [NUM_DIGITS-1:0] active_q, active_d;
  digit_t [NUM_DIGITS-1:0] captureIn;
  logic                    pending_q, pending_d;

  digit_t                  curDigit;
  logic [NUM_DIGITS-1:0]   lzBlank;
  logic                    curBlank;
  logic [6:0]              decodedSeg;
  logic [NUM_DIGITS-1:0]   digOneHot;

  logic [6:0]              segOut_q, segOut_d;
  logic                    dpOut_q, dpOut_d;
  logic [NUM_DIGITS-1:0]   digSel_q, digSel_d;
  logic                    framePulse_q;

  // Frame boundary = the last clock of the last digit's dwell; everything
  // frame-synchronous (content swap, blink counting, frame pulse) keys off it.
  assign dwellWrap = (dwellCnt_q == DWELL_LAST);
  assign frameWrap = dwellWrap && (digIdx_q == IDX_LAST);

  // Scan position and blink timing.
  always_comb begin
    dwellCnt_d   = dwellCnt_q + DW'(1);
    digIdx_d     = digIdx_q;
    frameCnt_d   = frameCnt_q;
    blinkPhase_d = blinkPhase_q;
    if (dwellWrap) begin
      dwellCnt_d = '0;
      digIdx_d   = (digIdx_q == IDX_LAST) ? '0 : digIdx_q + IW'(1);
    end
    if (frameWrap) begin
      if (frameCnt_q == FRAME_LAST) begin
        frameCnt_d   = '0;
        blinkPhase_d = (blinkPhase_q == BLINK_ON) ? BLINK_OFF : BLINK_ON;
      end else begin
        frameCnt_d = frameCnt_q + FW'(1);
      end
    end
  end

  // Repack the flat input buses into digit records.
  always_comb begin
    captureIn = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      captureIn[i].nibble = value[4*i +: 4];
      captureIn[i].en     = digit_en[i];
      captureIn[i].blink  = blink_mask[i];
      captureIn[i].dp     = dp[i];
    end
  end

  // Double buffering: the swap uses the staging contents from before this
  // edge, so an update landing on the boundary itself waits a whole frame
  // and keeps pending raised.
  always_comb begin
    staged_d  = update ? captureIn : staged_q;
    active_d  = (frameWrap && pending_q) ? staged_q : active_q;
    pending_d = update || (pending_q && !frameWrap);
  end

  // Leading-zero suppression walks down from the top digit and stops at the
  // first enabled nonzero digit or any disabled digit; digit 0 is exempt.
  always_comb begin
    lzBlank = '0;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    begin : lzScan
      logic lzSuppress;
      lzSuppress = 1'b1;
      for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
        if (lzSuppress && active_q[i].en && (active_q[i].nibble == 4'h0)) begin
          lzBlank[i] = 1'b1;
        end else begin
          lzSuppress = 1'b0;
        end
      end
    end
`endif
  end

  assign curDigit  = active_q[digIdx_q];
  assign digOneHot = NUM_DIGITS'(1) << digIdx_q;
  assign curBlank  = !curDigit.en
                  || (curDigit.blink && (blinkPhase_q == BLINK_OFF))
                  || lzBlank[digIdx_q];

  seg7_hex_decode uDecode (
    .nibble_i (curDigit.nibble),
    .seg_o    (decodedSeg)
  );

  // Output stage: a blanked digit still gets its select line so the scan
  // timing seen on dig_sel is independent of the content.
  always_comb begin
    segOut_d = SEG_OFF;
    dpOut_d  = DP_OFF;
    digSel_d = DIG_OFF;
    if (dwellCnt_q >= GHOST_END) begin
      digSel_d = digOneHot ^ {NUM_DIGITS{DIG_INV}};
      if (!curBlank) begin
        segOut_d = decodedSeg ^ {7{SEG_INV}};
        dpOut_d  = curDigit.dp ^ SEG_INV;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dwellCnt_q   <= '0;
      digIdx_q     <= '0;
      frameCnt_q   <= '0;
      blinkPhase_q <= BLINK_ON;
      staged_q     <= '0;
      active_q     <= '0;
      pending_q    <= 1'b0;
      segOut_q     <= SEG_OFF;
      dpOut_q      <= DP_OFF;
      digSel_q     <= DIG_OFF;
      framePulse_q <= 1'b0;
    end else begin
      dwellCnt_q   <= dwellCnt_d;
      digIdx_q     <= digIdx_d;
      frameCnt_q   <= frameCnt_d;
      blinkPhase_q <= blinkPhase_d;
      staged_q     <= staged_d;
      active_q     <= active_d;
      pending_q    <= pending_d;
      segOut_q     <= segOut_d;
      dpOut_q      <= dpOut_d;
      digSel_q     <= digSel_d;
      framePulse_q <= frameWrap;
    end
  end

  assign pending     = pending_q;
  assign seg_out     = segOut_q;
  assign dp_out      = dpOut_q;
  assign dig_sel     = digSel_q;
  assign frame_pulse = framePulse_q;

endmodule

// File: doc/seg7_scan_display.md
SEG7_SCAN_DISPLAY -- requirements
Module: seg7_scan_display

Interface
REQ-001 Parameter NUM_DIGITS, 4, digits scanned (1..8).
REQ-002 Parameter CLK_DIV, 50000, clocks per digit dwell (>= GHOST_CYCLES+2).
REQ-003 Parameter GHOST_CYCLES, 2, all-digits-off cycles at start of each dwell.
REQ-004 Parameter BLINK_FRAMES, 125, frames per blink half-period (>= 1).
REQ-005 Parameter SEG_ACTIVE_LOW, 1, segments/dp lit on 0 (common anode).
REQ-006 Parameter DIG_ACTIVE_LOW, 1, digit selects active on 0.
REQ-007 clk  input  1  single system clock, rising edge.
REQ-008 rst  input  1  asynchronous, active-high reset.
REQ-009 value  input  4*NUM_DIGITS  hex nibble per digit, digit 0 = LSBs.
REQ-010 digit_en  input  NUM_DIGITS  1 = digit shown, 0 = blanked.
REQ-011 blink_mask  input  NUM_DIGITS  1 = digit blinks.
REQ-012 dp  input  NUM_DIGITS  decimal point per digit.
REQ-013 update  input  1  one-cycle strobe capturing value/digit_en/blink_mask/dp.
REQ-014 pending  output  1  high from update until capture applied to display.
REQ-015 seg_out  output  7  segments, bit0 = a ... bit6 = g.
REQ-016 dp_out  output  1  decimal point of current digit.
REQ-017 dig_sel  output  NUM_DIGITS  one-hot (in active polarity) digit select.
REQ-018 frame_pulse  output  1  one-cycle pulse when scan wraps to digit 0.

Function
REQ-019 Dwell counter counts 0..CLK_DIV-1; at CLK_DIV-1 it wraps and digit index advances; index NUM_DIGITS-1 wraps to 0.
REQ-020 frame_pulse SHALL be high exactly in the cycle index wraps NUM_DIGITS-1 -> 0 (frame boundary).
REQ-021 While dwell counter < GHOST_CYCLES, dig_sel, seg_out and dp_out SHALL all be inactive.
REQ-022 Otherwise dig_sel activates only bit [index]; seg_out/dp_out show active digit [index]; outputs registered, one-cycle latency from counter state.
REQ-023 Hex map (active-high a..g): 0-9, A, b, C, d, E, F standard; e.g. 0 -> 0111111, 1 -> 0000110, 2 -> 1011011, 3 -> 1001111.
REQ-024 Digit blanked (segments and dp inactive, dig_sel still driven) if digit_en=0, or blink_mask=1 while blink phase=1.
REQ-025 Blink phase toggles after every BLINK_FRAMES frame boundaries; frame counter wraps at BLINK_FRAMES-1.
REQ-026 update SHALL copy inputs into staging registers and set pending; update while pending overwrites staging (newest wins).
REQ-027 At a frame boundary with pending=1, staging SHALL copy to active registers and pending clears next cycle; update in the boundary cycle itself is applied at the following boundary, pending stays 1.
REQ-028 Active registers never change mid-frame (no tearing).

Reset
REQ-029 On rst: dwell counter, index, frame counter, blink phase = 0; pending = 0; frame_pulse = 0.
REQ-030 On rst: staging and active registers = 0 (all digits disabled); seg_out, dp_out, dig_sel inactive per polarity parameters.
REQ-031 rst asserted mid-dwell or with pending=1 SHALL discard staged data; scan restarts at digit 0 with ghost interval after release.

Configuration
REQ-032 Macro SEG7_LEADING_ZERO_BLANK_EN defined: enabled digits from NUM_DIGITS-1 downward holding 0 are blanked until first nonzero or disabled digit; digit 0 always shown.
REQ-033 Macro undefined: no leading-zero blanking; all enabled digits shown.

Structure
REQ-034 Package seg7_pkg SHALL hold the 16-entry hex-to-segment table/function, SEG_BLANK constant and digit-record typedef (nibble, en, blink, dp).
REQ-035 Combinational sub-module seg7_hex_decode (nibble -> active-high segments) SHALL be instantiated once; polarity applied in seg7_scan_display.

Verification (NUM_DIGITS=4, CLK_DIV=8, GHOST_CYCLES=2, BLINK_FRAMES=2, active-low)
REQ-036 Reset release, no update -> dig_sel=1111, seg_out=1111111 indefinitely; frame_pulse every 32 cycles.
REQ-037 update value=0x3210, digit_en=1111 -> pending until next boundary; then digit 0 seg_out=1000000 dig_sel=1110, digit 3 seg_out=0110000 dig_sel=0111; cycles 0-1 of each dwell dig_sel=1111.
REQ-038 Two updates in one frame (0x1111 then 0x2222) -> only 0x2222 displayed; 0x1111 never appears.
REQ-039 blink_mask=0001 -> digit 0 lit for 2 frames, blank for 2 frames, repeating; other digits steady.
REQ-040 With SEG7_LEADING_ZERO_BLANK_EN, value=0x0050 -> digits 3,2 blank, digit 1 shows 5, digit 0 shows 0; without macro all four shown.
REQ-041 rst pulse mid-frame with pending=1 -> outputs inactive immediately, pending=0, display blank after release.
